// File: rtl/tl_rx_cpl_tag_tracker_if.sv
// ---------------------------------------------------------------------------
// tl_rx_cpl_tag_tracker_if
// Bundles the request, completion and status signals of the completion tag
// tracker.
//   master : the surrounding logic (drives configuration, TX requests and
//            RX completion headers; observes the tracker results)
//   slave  : the tracker itself
// Signals:
//   cfg_req_id, uc_en                         configuration
//   tx_req_valid/tag/byte_cnt                 non-posted request issued
//   rx_cpl_valid, rx_req_id/tag, rx_cpl_*     received completion header
//   uc_error(_tag), alloc_error, cpl_done(_tag), outstanding_cnt,
//   cpl_timeout(_tag)                         registered tracker results
// ---------------------------------------------------------------------------
interface tl_rx_cpl_tag_tracker_if #(
  parameter int unsigned REQUESTER_ID_WIDTH  = 16,
  parameter int unsigned REQUESTER_TAG_WIDTH = 10,
  parameter int unsigned NUM_TAGS            = 32,
  parameter int unsigned BYTE_COUNT_WIDTH    = 13
);
  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

  logic [REQUESTER_ID_WIDTH-1:0]  cfg_req_id;
  logic                           uc_en;
  logic                           tx_req_valid;
  logic [REQUESTER_TAG_WIDTH-1:0] tx_req_tag;
  logic [BYTE_COUNT_WIDTH-1:0]    tx_req_byte_cnt;
  logic                           rx_cpl_valid;
  logic [REQUESTER_ID_WIDTH-1:0]  rx_req_id;
  logic [REQUESTER_TAG_WIDTH-1:0] rx_req_tag;
  logic [2:0]                     rx_cpl_status;
  logic [BYTE_COUNT_WIDTH-1:0]    rx_cpl_byte_cnt;
  logic [BYTE_COUNT_WIDTH-1:0]    rx_cpl_payload_bytes;
  logic                           uc_error;
  logic [REQUESTER_TAG_WIDTH-1:0] uc_error_tag;
  logic                           alloc_error;
  logic                           cpl_done;
  logic [REQUESTER_TAG_WIDTH-1:0] cpl_done_tag;
  logic [CNT_W-1:0]               outstanding_cnt;
  logic                           cpl_timeout;
  logic [REQUESTER_TAG_WIDTH-1:0] cpl_timeout_tag;

  modport master (
    output cfg_req_id, uc_en, tx_req_valid, tx_req_tag, tx_req_byte_cnt,
           rx_cpl_valid, rx_req_id, rx_req_tag, rx_cpl_status,
           rx_cpl_byte_cnt, rx_cpl_payload_bytes,
    input  uc_error, uc_error_tag, alloc_error, cpl_done, cpl_done_tag,
           outstanding_cnt, cpl_timeout, cpl_timeout_tag
  );

  modport slave (
    input  cfg_req_id, uc_en, tx_req_valid, tx_req_tag, tx_req_byte_cnt,
           rx_cpl_valid, rx_req_id, rx_req_tag, rx_cpl_status,
           rx_cpl_byte_cnt, rx_cpl_payload_bytes,
    output uc_error, uc_error_tag, alloc_error, cpl_done, cpl_done_tag,
           outstanding_cnt, cpl_timeout, cpl_timeout_tag
  );
endinterface

// File: rtl/tl_rx_cpl_tag_tracker.sv
// ---------------------------------------------------------------------------
// tl_rx_cpl_tag_tracker
// Outstanding non-posted request tracker. Every tag issued by TX is recorded
// with its expected byte count; received completions are matched against the
// table, final/error completions retire the tag, and unexpected completions
// and illegal allocations are flagged. All results are registered pulses that
// appear the cycle after the triggering input.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (drops all outstanding tags)
//   bus      tl_rx_cpl_tag_tracker_if.slave (requests, completions, results)
//
// Optional feature macro: TL_RX_CPL_TIMEOUT_EN
//   When defined, a prescaler ticks every TICK_DIV cycles and a per-tag age
//   counter (TIMEOUT_WIDTH bits) retires stale tags through cpl_timeout.
//   When undefined, cpl_timeout and cpl_timeout_tag are tied to zero.
// ---------------------------------------------------------------------------
module tl_rx_cpl_tag_tracker #(
  parameter int unsigned REQUESTER_ID_WIDTH  = 16,
  parameter int unsigned REQUESTER_TAG_WIDTH = 10,
  parameter int unsigned NUM_TAGS            = 32,
  parameter int unsigned BYTE_COUNT_WIDTH    = 13,
  parameter int unsigned TIMEOUT_WIDTH       = 8,
  parameter int unsigned TICK_DIV            = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  tl_rx_cpl_tag_tracker_if.slave       bus
);
  localparam int unsigned TAG_W = REQUESTER_TAG_WIDTH;
  localparam int unsigned BC_W  = BYTE_COUNT_WIDTH;
  localparam int unsigned IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);
  localparam int          NT    = int'(NUM_TAGS);
  // One extra bit so NUM_TAGS == 2^TAG_W still compares correctly.
  localparam logic [TAG_W:0] NUM_TAGS_EXT = (TAG_W + 1)'(NUM_TAGS);
  localparam logic [2:0]     STATUS_SC    = 3'b000;

  if (NUM_TAGS < 1 || NUM_TAGS > (1 << REQUESTER_TAG_WIDTH) ||
      TIMEOUT_WIDTH < 1 || TICK_DIV < 1) begin : g_bad_cfg
    $error("tl_rx_cpl_tag_tracker: illegal parameter combination");
  end

  // Tag table and registered outputs
  logic [NUM_TAGS-1:0] r_busy;
  logic [BC_W-1:0]     r_remaining [NUM_TAGS];
  logic                r_uc_error;
  logic [TAG_W-1:0]    r_uc_error_tag;
  logic                r_alloc_error;
  logic                r_cpl_done;
  logic [TAG_W-1:0]    r_cpl_done_tag;
  logic [CNT_W-1:0]    r_outstanding_cnt;
  logic                r_cpl_timeout;
  logic [TAG_W-1:0]    r_cpl_timeout_tag;

  // Decode
  logic             w_cpl_in_range;
  logic [IDX_W-1:0] w_cpl_idx;
  logic             w_cpl_busy;
  logic [BC_W-1:0]  w_cpl_rem;
  logic             w_cpl_sc;
  logic             w_cpl_match;
  logic             w_cpl_retire;
  logic             w_cpl_partial;
  logic             w_uc;
  logic             w_alloc_in_range;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_alloc_legal;
  logic             w_to_retire;
  logic [IDX_W-1:0] w_to_idx;

  // Completion matching against the pre-edge table state
  always_comb begin
    w_cpl_in_range = ({1'b0, bus.rx_req_tag} < NUM_TAGS_EXT);
    w_cpl_idx      = bus.rx_req_tag[IDX_W-1:0];
    w_cpl_busy     = w_cpl_in_range && r_busy[w_cpl_idx];
    w_cpl_rem      = r_remaining[w_cpl_idx];
    w_cpl_sc       = (bus.rx_cpl_status == STATUS_SC);
    w_cpl_match    = bus.rx_cpl_valid && (bus.rx_req_id == bus.cfg_req_id) &&
                     w_cpl_busy && (!w_cpl_sc || (bus.rx_cpl_byte_cnt == w_cpl_rem));
    // Error status always retires; SC retires once the payload covers the rest.
    w_cpl_retire   = w_cpl_match && (!w_cpl_sc || (bus.rx_cpl_payload_bytes >= w_cpl_rem));
    w_cpl_partial  = w_cpl_match && !w_cpl_retire;
    w_uc           = bus.rx_cpl_valid && !w_cpl_match && bus.uc_en;
  end

  // Allocation legality; a tag retiring this cycle may be reissued at once
  always_comb begin
    w_alloc_in_range = ({1'b0, bus.tx_req_tag} < NUM_TAGS_EXT);
    w_alloc_idx      = bus.tx_req_tag[IDX_W-1:0];
    w_alloc_legal    = bus.tx_req_valid && w_alloc_in_range &&
                       (!r_busy[w_alloc_idx] ||
                        (w_cpl_retire && (w_cpl_idx == w_alloc_idx)) ||
                        (w_to_retire && (w_to_idx == w_alloc_idx)));
  end

`ifdef TL_RX_CPL_TIMEOUT_EN
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] AGE_MAX = {TIMEOUT_WIDTH{1'b1}};

  logic [PRESC_W-1:0]       r_presc;
  logic [TIMEOUT_WIDTH-1:0] r_age [NUM_TAGS];
  logic                     w_tick;
  logic [NUM_TAGS-1:0]      w_to_cand;

  assign w_tick = (r_presc == PRESC_LAST);

  // Timeout candidates; a tag hit by a matched completion is left to the completion
  always_comb begin
    w_to_cand = {NUM_TAGS{1'b0}};
    for (int i = 0; i < NT; i++) begin
      w_to_cand[i] = r_busy[i] && (r_age[i] == AGE_MAX) &&
                     !(w_cpl_match && (w_cpl_idx == IDX_W'(i)));
    end
  end

  // Lowest-index timed-out tag wins
  always_comb begin
    w_to_retire = 1'b0;
    w_to_idx    = {IDX_W{1'b0}};
    for (int i = NT - 1; i >= 0; i--) begin
      if (w_to_cand[i]) begin
        w_to_retire = 1'b1;
        w_to_idx    = IDX_W'(i);
      end else begin
        w_to_idx    = w_to_idx;
      end
    end
  end

  // Age tick prescaler
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= {PRESC_W{1'b0}};
    end else if (w_tick) begin
      r_presc <= {PRESC_W{1'b0}};
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Per-tag saturating age counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NT; i++) r_age[i] <= {TIMEOUT_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NT; i++) begin
        if ((w_alloc_legal && (w_alloc_idx == IDX_W'(i))) ||
            (w_cpl_match && (w_cpl_idx == IDX_W'(i))) ||
            (w_to_retire && (w_to_idx == IDX_W'(i))) ||
            !r_busy[i]) begin
          r_age[i] <= {TIMEOUT_WIDTH{1'b0}};
        end else if (w_tick && (r_age[i] != AGE_MAX)) begin
          r_age[i] <= r_age[i] + TIMEOUT_WIDTH'(1);
        end
      end
    end
  end
`else
  assign w_to_retire = 1'b0;
  assign w_to_idx    = {IDX_W{1'b0}};
`endif

  // Tag table, outstanding count and registered result pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy            <= {NUM_TAGS{1'b0}};
      for (int i = 0; i < NT; i++) r_remaining[i] <= {BC_W{1'b0}};
      r_uc_error        <= 1'b0;
      r_uc_error_tag    <= {TAG_W{1'b0}};
      r_alloc_error     <= 1'b0;
      r_cpl_done        <= 1'b0;
      r_cpl_done_tag    <= {TAG_W{1'b0}};
      r_outstanding_cnt <= {CNT_W{1'b0}};
      r_cpl_timeout     <= 1'b0;
      r_cpl_timeout_tag <= {TAG_W{1'b0}};
    end else begin
      r_uc_error    <= w_uc;
      r_alloc_error <= bus.tx_req_valid && !w_alloc_legal;
      r_cpl_done    <= w_cpl_retire;
      r_cpl_timeout <= w_to_retire;
      if (w_uc)         r_uc_error_tag    <= bus.rx_req_tag;
      if (w_cpl_retire) r_cpl_done_tag    <= bus.rx_req_tag;
      if (w_to_retire)  r_cpl_timeout_tag <= TAG_W'(w_to_idx);

      if (w_cpl_retire) begin
        r_busy[w_cpl_idx] <= 1'b0;
      end else if (w_cpl_partial) begin
        r_remaining[w_cpl_idx] <= w_cpl_rem - bus.rx_cpl_payload_bytes;
      end
      if (w_to_retire) r_busy[w_to_idx] <= 1'b0;
      // Allocation is applied last so a same-cycle reissue of a retiring tag sticks.
      if (w_alloc_legal) begin
        r_busy[w_alloc_idx]      <= 1'b1;
        r_remaining[w_alloc_idx] <= bus.tx_req_byte_cnt;
      end

      r_outstanding_cnt <= r_outstanding_cnt + CNT_W'(w_alloc_legal)
                           - CNT_W'(w_cpl_retire) - CNT_W'(w_to_retire);
    end
  end

  assign bus.uc_error        = r_uc_error;
  assign bus.uc_error_tag    = r_uc_error_tag;
  assign bus.alloc_error     = r_alloc_error;
  assign bus.cpl_done        = r_cpl_done;
  assign bus.cpl_done_tag    = r_cpl_done_tag;
  assign bus.outstanding_cnt = r_outstanding_cnt;
  assign bus.cpl_timeout     = r_cpl_timeout;
  assign bus.cpl_timeout_tag = r_cpl_timeout_tag;
endmodule
